// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 stride-2 pooling stream.
//   POOL_MAX / POOL_AVG : pooling mode encodings for the MODE parameter
//   cnt_width(n)        : bits needed to count 0..n-1 (minimum 1)
package pool_pkg;

  localparam int POOL_MAX = 0;
  localparam int POOL_AVG = 1;

  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/pool_combine.sv
// Two-operand combiner for one channel of a pooling window.
//   a, b : unsigned operands, IW bits
//   y    : MODE POOL_AVG -> a + b (OW bits, caller sizes OW so the sum fits)
//          MODE POOL_MAX -> max(a, b), zero-extended to OW bits
module pool_combine
  import pool_pkg::*;
#(
  parameter int IW   = 8,
  parameter int OW   = 9,
  parameter int MODE = POOL_MAX
) (
  input  logic [IW-1:0] a,
  input  logic [IW-1:0] b,
  output logic [OW-1:0] y
);

  if (MODE == POOL_AVG) begin : g_add
    assign y = OW'(a) + OW'(b);
  end else begin : g_max
    assign y = (a > b) ? OW'(a) : OW'(b);
  end

endmodule

// File: rtl/pool_stream.sv
// Streaming 2x2 / stride-2 pooling over a W x H feature map, C channels per beat.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_data/valid/ready   : raster-order input pixels, channel c at [c*DW +: DW]
//   out_data/valid/ready  : raster-order pooled pixels, (W/2) x (H/2) per frame
//   out_last              : marks the final pooled pixel of a frame
//
// Handshake: a beat moves on a port in any cycle where valid && ready are both
// high at the rising edge. The output is a single register; in_ready is high
// whenever that register is empty or being drained this cycle, so an input beat
// that completes a window can always be stored without loss.
module pool_stream
  import pool_pkg::*;
#(
  parameter int DW   = 8,
  parameter int W    = 6,
  parameter int H    = 6,
  parameter int C    = 3,
  parameter int MODE = POOL_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [C*DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [C*DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  localparam int CW  = cnt_width(W);
  localparam int RW  = cnt_width(H);
  localparam int LBW = cnt_width(W / 2);

  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [C*DW-1:0] pair_q;
  // Horizontal results of the even row, one entry per output column.
  logic [DW+1:0]   lbuf_q [W/2][C];

  logic            in_fire;
  logic            last_px;
  logic [LBW-1:0]  lb_idx;
  logic [DW:0]     h_res [C];
  logic [DW+1:0]   v_res [C];
  logic [C*DW-1:0] pooled;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign lb_idx   = LBW'(col_q >> 1);
  assign last_px  = (row_q == RW'(H - 1)) && (col_q == CW'(W - 1));

  for (genvar c = 0; c < C; c++) begin : g_ch
    pool_combine #(.IW(DW), .OW(DW + 1), .MODE(MODE)) u_h (
      .a (pair_q[c*DW +: DW]),
      .b (in_data[c*DW +: DW]),
      .y (h_res[c])
    );
    pool_combine #(.IW(DW + 2), .OW(DW + 2), .MODE(MODE)) u_v (
      .a (lbuf_q[lb_idx][c]),
      .b ({1'b0, h_res[c]}),
      .y (v_res[c])
    );
    // Average divides the 4-value sum by 4 by dropping two LSBs.
    assign pooled[c*DW +: DW] = (MODE == POOL_AVG) ? v_res[c][DW+1:2] : v_res[c][DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      pair_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (in_fire) begin
        if (col_q == CW'(W - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RW'(H - 1)) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        if (!col_q[0]) begin
          pair_q <= in_data;
        end else if (row_q[0]) begin
          // Overrides the drain above when both happen in one cycle.
          out_data  <= pooled;
          out_valid <= 1'b1;
          out_last  <= last_px;
        end
      end
    end
  end

  // No reset: each entry is written on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (in_fire && col_q[0] && !row_q[0]) begin
      for (int c = 0; c < C; c++) lbuf_q[lb_idx][c] <= {1'b0, h_res[c]};
    end
  end

endmodule

// File: tb/tb_pool_stream.sv
// Bench for pool_stream: one max-pool and one average-pool instance driven
// independently, each checked against a frame-array reference model.
module tb_pool_stream;
  import pool_pkg::*;

  localparam int DW = 8;
  localparam int W  = 6;
  localparam int H  = 6;
  localparam int C  = 3;
  localparam int PW = C * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [PW-1:0] in_data  [2];
  logic          in_valid [2];
  logic          in_ready [2];
  logic [PW-1:0] out_data [2];
  logic          out_valid[2];
  logic          out_ready[2];
  logic          out_last [2];

  pool_stream #(.DW(DW), .W(W), .H(H), .C(C), .MODE(POOL_MAX)) u_max (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0])
  );

  pool_stream #(.DW(DW), .W(W), .H(H), .C(C), .MODE(POOL_AVG)) u_avg (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1])
  );

  // ---------------- scoreboard state ----------------
  logic [PW:0]   exp_q0[$], exp_q1[$];   // {last, data}
  logic [PW-1:0] got0[$], got1[$];
  logic [PW-1:0] ref0[$], ref1[$];
  logic [PW-1:0] frame [2][W*H];
  int            pos [2];
  logic          prev_stall [2];
  logic [PW:0]   prev_out [2];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Reference: once a frame position completes a 2x2 window, pool it directly
  // from the stored input pixels.
  task automatic model_beat(input int d, input logic [PW-1:0] px);
    int r, k, v[4], res;
    logic [PW-1:0] o;
    frame[d][pos[d]] = px;
    r = pos[d] / W;
    k = pos[d] % W;
    if ((r % 2 == 1) && (k % 2 == 1)) begin
      for (int c = 0; c < C; c++) begin
        v[0] = int'(frame[d][(r-1)*W + k-1][c*DW +: DW]);
        v[1] = int'(frame[d][(r-1)*W + k][c*DW +: DW]);
        v[2] = int'(frame[d][r*W + k-1][c*DW +: DW]);
        v[3] = int'(frame[d][r*W + k][c*DW +: DW]);
        if (d == 0) begin
          res = v[0];
          for (int i = 1; i < 4; i++) if (v[i] > res) res = v[i];
        end else begin
          res = (v[0] + v[1] + v[2] + v[3]) / 4;
        end
        o[c*DW +: DW] = DW'(res);
      end
      if (d == 0) exp_q0.push_back({pos[d] == W*H-1, o});
      else        exp_q1.push_back({pos[d] == W*H-1, o});
    end
    pos[d] = (pos[d] + 1) % (W*H);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [PW:0] e;
    for (int d = 0; d < 2; d++) begin pos[d] = 0; prev_stall[d] = 1'b0; prev_out[d] = '0; end
    forever begin
      @(negedge clk);
      #4;
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          pos[d] = 0;
          prev_stall[d] = 1'b0;
          if (d == 0) exp_q0.delete(); else exp_q1.delete();
        end else begin
          check($sformatf("in_ready_d%0d", d), in_ready[d], !out_valid[d] || out_ready[d]);
          if (prev_stall[d]) begin
            check($sformatf("hold_valid_d%0d", d), out_valid[d], 1'b1);
            check($sformatf("hold_out_d%0d", d), {out_last[d], out_data[d]}, prev_out[d]);
          end
          if (out_valid[d] && out_ready[d]) begin
            if (q_size(d) == 0) begin
              check($sformatf("unexpected_out_d%0d", d), 1'b1, 1'b0);
            end else begin
              e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check($sformatf("out_d%0d", d), {out_last[d], out_data[d]}, e);
            end
            if (d == 0) got0.push_back(out_data[d]); else got1.push_back(out_data[d]);
          end
          if (in_valid[d] && in_ready[d]) model_beat(d, in_data[d]);
          prev_stall[d] = out_valid[d] && !out_ready[d];
          prev_out[d]   = {out_last[d], out_data[d]};
        end
      end
    end
  end

  // ---------------- driver ----------------
  int            idx  [2];
  logic          have [2];
  logic [PW-1:0] cur  [2];

  // kind 0 random, 1 ramp row*W+col+c*40, 2 ch0 window 1,2,3,4, 3 all ones
  function automatic logic [PW-1:0] pixel(input int kind, input int n);
    int r, k;
    logic [PW-1:0] p;
    r = (n / W) % H;
    k = n % W;
    for (int c = 0; c < C; c++) begin
      case (kind)
        1:       p[c*DW +: DW] = DW'(r*W + k + c*40);
        2:       p[c*DW +: DW] = (c == 0) ? DW'((r % 2)*2 + (k % 2) + 1) : DW'($urandom_range(0, 255));
        3:       p[c*DW +: DW] = '1;
        default: p[c*DW +: DW] = DW'($urandom_range(0, 255));
      endcase
    end
    return p;
  endfunction

  // Called at a falling edge; returns at a falling edge.
  task automatic run_beats(input int n, input int kind, input int vpct, input int rpct);
    int sent [2];
    int cycles;
    sent[0] = 0; sent[1] = 0; cycles = 0;
    have[0] = 1'b0; have[1] = 1'b0;
    while ((sent[0] < n || sent[1] < n) && cycles < 30000) begin
      for (int d = 0; d < 2; d++) begin
        if (sent[d] < n && !have[d]) begin cur[d] = pixel(kind, idx[d]); have[d] = 1'b1; end
        in_valid[d]  = have[d] && ($urandom_range(1, 100) <= vpct);
        in_data[d]   = cur[d];
        out_ready[d] = ($urandom_range(1, 100) <= rpct);
      end
      #4;
      for (int d = 0; d < 2; d++)
        if (in_valid[d] && in_ready[d]) begin sent[d]++; idx[d]++; have[d] = 1'b0; end
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 30000) check("drive_timeout", 1'b1, 1'b0);
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
  endtask

  task automatic drain();
    int cycles;
    logic done;
    cycles = 0; done = 1'b0;
    while (!done && cycles < 60) begin
      for (int d = 0; d < 2; d++) begin in_valid[d] = 1'b0; out_ready[d] = 1'b1; end
      #4;
      done = (exp_q0.size() == 0) && (exp_q1.size() == 0) && !out_valid[0] && !out_valid[1];
      @(negedge clk);
      cycles++;
    end
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; idx[d] = 0; have[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_valid_d%0d", d), out_valid[d], 1'b0);
      check($sformatf("rst_last_d%0d", d), out_last[d], 1'b0);
      check($sformatf("rst_data_d%0d", d), out_data[d], '0);
      check($sformatf("rst_ready_d%0d", d), in_ready[d], 1'b1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready_d0", in_ready[0], 1'b1);
    check("post_rst_ready_d1", in_ready[1], 1'b1);
    @(negedge clk);
  endtask

  function automatic void clear_got();
    got0.delete();
    got1.delete();
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin in_data[d] = '0; cur[d] = '0; end
    do_reset();

    // Ramp frame, no stalls.
    clear_got();
    run_beats(W*H, 1, 100, 100);
    drain();
    check("ramp_cnt_max", got0.size(), 9);
    check("ramp_cnt_avg", got1.size(), 9);
    if (got0.size() == 9 && got1.size() == 9) begin
      check("ramp_max_first_ch0", got0[0][7:0], 8'd7);
      check("ramp_max_first_ch1", got0[0][15:8], 8'd47);
      check("ramp_max_last_ch0", got0[8][7:0], 8'd35);
      check("ramp_avg_first_ch0", got1[0][7:0], 8'd3);
      check("ramp_avg_last_ch0", got1[8][7:0], 8'd31);
    end
    ref0 = got0;
    ref1 = got1;

    // Average of window 1,2,3,4 and saturated inputs.
    clear_got();
    run_beats(W*H, 2, 100, 100);
    drain();
    for (int i = 0; i < got1.size(); i++) check("avg_1234_ch0", got1[i][7:0], 8'd2);
    clear_got();
    run_beats(W*H, 3, 80, 100);
    drain();
    if (got0.size() > 0 && got1.size() > 0) begin
      check("max_all_ones", got0[0], {PW{1'b1}});
      check("avg_all_ones", got1[got1.size()-1], {PW{1'b1}});
    end else begin
      check("all_ones_cnt", 1'b0, 1'b1);
    end

    // Heavy downstream back-pressure must not change the result.
    clear_got();
    run_beats(W*H, 1, 100, 20);
    drain();
    check("stall_cnt_max", got0.size(), ref0.size());
    check("stall_cnt_avg", got1.size(), ref1.size());
    for (int i = 0; i < got0.size() && i < ref0.size(); i++) check("stall_vs_clean_max", got0[i], ref0[i]);
    for (int i = 0; i < got1.size() && i < ref1.size(); i++) check("stall_vs_clean_avg", got1[i], ref1[i]);

    // Reset in the middle of a frame, then a clean ramp frame.
    run_beats(20, 0, 100, 100);
    do_reset();
    clear_got();
    run_beats(W*H, 1, 100, 100);
    drain();
    check("post_rst_cnt", got0.size(), 9);
    for (int i = 0; i < got0.size() && i < ref0.size(); i++) check("post_rst_max", got0[i], ref0[i]);
    for (int i = 0; i < got1.size() && i < ref1.size(); i++) check("post_rst_avg", got1[i], ref1[i]);

    // 100 back-to-back random frames with random handshakes.
    clear_got();
    run_beats(100*W*H, 0, 60, 70);
    drain();
    check("rand_cnt_max", got0.size(), 900);
    check("rand_cnt_avg", got1.size(), 900);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pool_stream.md
POOL_STREAM -- requirements
Module: pool_stream

Interface
REQ-001 Parameter DW, default 8, bit width of one unsigned feature value.
REQ-002 Parameter W, default 6, input feature-map width in pixels; even, >= 2.
REQ-003 Parameter H, default 6, input feature-map height in pixels; even, >= 2.
REQ-004 Parameter C, default 3, channel count carried in parallel per beat.
REQ-005 Parameter MODE, default 0, pooling mode: 0 = 2x2 max, 1 = 2x2 average.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_data  input  C*DW  one input pixel; channel c at [c*DW +: DW].
REQ-009 in_valid  input  1  in_data valid.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 out_data  output  C*DW  one pooled pixel; channel c at [c*DW +: DW].
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_last  output  1  high with the final pooled pixel of a frame.

Function
REQ-015 Input beats arrive in raster order (row 0 col 0 .. row H-1 col W-1), one pixel of all C channels per beat; a beat transfers when in_valid && in_ready.
REQ-016 Output is (W/2) x (H/2) pixels in raster order; output (r,k) pools input rows 2r,2r+1, cols 2k,2k+1, per channel, stride 2, no padding.
REQ-017 Column counter (0..W-1) and row counter (0..H-1) advance per accepted beat; both wrap to 0 after (H-1,W-1), and the next beat starts a new frame with no idle cycle.
REQ-018 Even column: hold pixel in a pair register; odd column: combine with pair register (max, or DW+1-bit sum).
REQ-019 Even row, odd column: write horizontal result into line buffer entry col/2 (depth W/2, C entries of DW+2 bits).
REQ-020 Odd row, odd column: combine horizontal result with line buffer entry col/2 and load the output register.
REQ-021 MODE 0: out = max of 4 values, unsigned compare.
REQ-022 MODE 1: out = (sum of 4 values, DW+2 bits) >> 2, truncating, unsigned; no overflow possible.
REQ-023 Latency: out_valid rises the cycle after the transfer of the completing input beat.
REQ-024 Output register is a one-entry buffer: out_valid holds, with out_data/out_last stable, until out_valid && out_ready.
REQ-025 in_ready = !out_valid || out_ready; with output full and out_ready low, no beat is accepted on any row/column.
REQ-026 Completing-beat transfer and output drain in the same cycle: output register loads new value, out_valid stays 1.
REQ-027 out_last = 1 exactly when the loaded pixel is output (H/2-1, W/2-1).
REQ-028 in_valid low: counters, pair register, line buffer, output untouched.

Reset
REQ-029 rst_n low: out_valid=0, out_last=0, out_data=0, column and row counters=0, pair register=0, regardless of clock.
REQ-030 in_ready reads 1 during and immediately after reset.
REQ-031 Reset mid-frame discards the partial frame; the first beat after release is row 0 col 0.
REQ-032 Line buffer contents need no reset; never read before written in a frame.

Structure
REQ-033 Shared package pool_pkg holds MODE encodings (POOL_MAX=0, POOL_AVG=1) and a function computing counter widths.
REQ-034 One sub-module pool_combine (per-channel 2-operand max/add, MODE-selected), instantiated C times for horizontal and C times for vertical.
REQ-035 Line buffer implemented as a register array; no vendor memory.

Verification
REQ-036 Default params, MODE 0, in_data ch c = row*6+col+c*40, no stalls -> 9 outputs, ch0 of first = 7, last = 35, out_last only on 9th.
REQ-037 MODE 1, 2x2 window ch0 = 1,2,3,4 -> out ch0 = 2; all values 0xFF -> 0xFF.
REQ-038 out_ready held low 5 cycles while output pending -> in_ready low, out_data stable, no beat lost; output matches no-stall run.
REQ-039 rst_n pulsed after 20 beats, then a full frame -> output identical to clean frame, no leftover data.
REQ-040 100 frames back-to-back, random in_valid/out_ready -> every pooled byte matches golden pooled file from 6x6x3 convolution samples.
